// File: rtl/vga_sync_monitor_if.sv
// Sync pins coming into the monitor and the timing results it reports back.
interface vga_sync_monitor_if;
    logic        hsync_in;
    logic        vsync_in;
    logic [11:0] h_pos;
    logic [10:0] v_pos;
    logic        line_start;
    logic        frame_start;
    logic [11:0] line_len;
    logic [11:0] hs_width;
    logic [10:0] frame_lines;
    logic        locked;
    logic        sync_err;

    modport master (
        output hsync_in, vsync_in,
        input  h_pos, v_pos, line_start, frame_start,
        input  line_len, hs_width, frame_lines, locked, sync_err
    );

    modport slave (
        input  hsync_in, vsync_in,
        output h_pos, v_pos, line_start, frame_start,
        output line_len, hs_width, frame_lines, locked, sync_err
    );
endinterface

// File: rtl/vga_sync_monitor.sv
// Recovers line/frame position from incoming hsync/vsync, measures line length,
// hsync width and frame height, and tracks lock against the expected timing.
module vga_sync_monitor #(
    parameter int H_TOTAL     = 1041,
    parameter int V_TOTAL     = 667,
    parameter int HS_WIDTH    = 120,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst,
    vga_sync_monitor_if.slave vif
);
    localparam logic [11:0] H_TOTAL_C  = 12'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_C  = 11'(V_TOTAL);
    localparam logic [11:0] HS_WIDTH_C = 12'(HS_WIDTH);
    localparam logic [3:0]  LOCK_C     = 4'(LOCK_FRAMES);
    localparam logic [11:0] H_MAX      = 12'hFFF;
    localparam logic [10:0] V_MAX      = 11'h7FF;

    typedef enum logic [1:0] {UNLOCKED, MEASURE, LOCKED} state_t;

    state_t      state_q, state_d;
    logic        hs_meta_q, hs_meta_d, hs_sync_q, hs_sync_d, hs_dly_q, hs_dly_d;
    logic        vs_meta_q, vs_meta_d, vs_sync_q, vs_sync_d, vs_dly_q, vs_dly_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] w_cnt_q, w_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [11:0] line_len_q, line_len_d;
    logic [11:0] hs_width_q, hs_width_d;
    logic [10:0] frame_lines_q, frame_lines_d;
    logic        hs_armed_q, hs_armed_d, vs_armed_q, vs_armed_d;
    logic        line_bad_q, line_bad_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic        line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic        locked_q, locked_d, sync_err_q, sync_err_d;

    logic        hs_rise, hs_fall, vs_rise, timeout;
    logic [11:0] len_p1;
    logic        line_bad_evt, frame_ok;

    always_comb begin
        hs_meta_d = vif.hsync_in;
        hs_sync_d = hs_meta_q;
        hs_dly_d  = hs_sync_q;
        vs_meta_d = vif.vsync_in;
        vs_sync_d = vs_meta_q;
        vs_dly_d  = vs_sync_q;

        hs_rise = hs_sync_q & ~hs_dly_q;
        hs_fall = ~hs_sync_q & hs_dly_q;
        vs_rise = vs_sync_q & ~vs_dly_q;
        timeout = (h_cnt_q == H_MAX);
        len_p1  = timeout ? H_MAX : h_cnt_q + 12'd1;

        // Any malformed line, or a dead hsync, spoils the frame in progress.
        line_bad_evt = (hs_rise & hs_armed_q & (len_p1 != H_TOTAL_C))
                     | (hs_fall & hs_armed_q & (w_cnt_q != HS_WIDTH_C))
                     | timeout;
        frame_ok = (v_cnt_q == V_TOTAL_C) & ~line_bad_q & ~line_bad_evt;

        h_cnt_d = hs_rise ? 12'd0 : (timeout ? h_cnt_q : h_cnt_q + 12'd1);

        w_cnt_d = w_cnt_q;
        if (hs_fall)
            w_cnt_d = 12'd0;
        else if (hs_sync_q && w_cnt_q != H_MAX)
            w_cnt_d = w_cnt_q + 12'd1;

        // A vsync edge restarts the line count; a coincident hsync edge is line 0.
        v_cnt_d = v_cnt_q;
        if (vs_rise)
            v_cnt_d = {10'd0, hs_rise};
        else if (hs_rise && v_cnt_q != V_MAX)
            v_cnt_d = v_cnt_q + 11'd1;

        line_len_d    = (hs_rise & hs_armed_q) ? len_p1 : line_len_q;
        hs_width_d    = (hs_fall & hs_armed_q) ? w_cnt_q : hs_width_q;
        frame_lines_d = (vs_rise & vs_armed_q) ? v_cnt_q : frame_lines_q;
        hs_armed_d    = hs_rise | (hs_armed_q & ~timeout);
        vs_armed_d    = vs_rise | (vs_armed_q & ~timeout);
        line_bad_d    = vs_rise ? 1'b0 : (line_bad_q | line_bad_evt);

        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        sync_err_d = 1'b0;
        case (state_q)
            UNLOCKED: begin
                if (vs_rise) begin
                    state_d    = MEASURE;
                    good_cnt_d = 4'd0;
                end
            end
            MEASURE: begin
                if (timeout) begin
                    state_d    = UNLOCKED;
                    good_cnt_d = 4'd0;
                end else if (vs_rise) begin
                    if (frame_ok) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        if (good_cnt_d == LOCK_C)
                            state_d = LOCKED;
                    end else begin
                        good_cnt_d = 4'd0;
                    end
                end
            end
            LOCKED: begin
                if (line_bad_evt || (vs_rise && !frame_ok)) begin
                    state_d    = MEASURE;
                    good_cnt_d = 4'd0;
                    sync_err_d = 1'b1;
                end
            end
            default: begin
                state_d    = UNLOCKED;
                good_cnt_d = 4'd0;
            end
        endcase

        line_start_d  = hs_rise;
        frame_start_d = vs_rise;
        locked_d      = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= UNLOCKED;
            hs_meta_q     <= 1'b0;
            hs_sync_q     <= 1'b0;
            hs_dly_q      <= 1'b0;
            vs_meta_q     <= 1'b0;
            vs_sync_q     <= 1'b0;
            vs_dly_q      <= 1'b0;
            h_cnt_q       <= 12'd0;
            w_cnt_q       <= 12'd0;
            v_cnt_q       <= 11'd0;
            line_len_q    <= 12'd0;
            hs_width_q    <= 12'd0;
            frame_lines_q <= 11'd0;
            hs_armed_q    <= 1'b0;
            vs_armed_q    <= 1'b0;
            line_bad_q    <= 1'b0;
            good_cnt_q    <= 4'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_meta_q     <= hs_meta_d;
            hs_sync_q     <= hs_sync_d;
            hs_dly_q      <= hs_dly_d;
            vs_meta_q     <= vs_meta_d;
            vs_sync_q     <= vs_sync_d;
            vs_dly_q      <= vs_dly_d;
            h_cnt_q       <= h_cnt_d;
            w_cnt_q       <= w_cnt_d;
            v_cnt_q       <= v_cnt_d;
            line_len_q    <= line_len_d;
            hs_width_q    <= hs_width_d;
            frame_lines_q <= frame_lines_d;
            hs_armed_q    <= hs_armed_d;
            vs_armed_q    <= vs_armed_d;
            line_bad_q    <= line_bad_d;
            good_cnt_q    <= good_cnt_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign vif.h_pos       = h_cnt_q;
    assign vif.v_pos       = v_cnt_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
    assign vif.line_len    = line_len_q;
    assign vif.hs_width    = hs_width_q;
    assign vif.frame_lines = frame_lines_q;
    assign vif.locked      = locked_q;
    assign vif.sync_err    = sync_err_q;
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor: a table of frames is driven onto the sync pins and
// the expected measurements at each frame start are scoreboarded and compared.
module tb_vga_sync_monitor;
    localparam int HT = 40;
    localparam int HW = 6;
    localparam int VT = 12;
    localparam int NROWS = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_sync_monitor_if vif();

    vga_sync_monitor #(
        .H_TOTAL(HT), .V_TOTAL(VT), .HS_WIDTH(HW), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vif(vif.slave)
    );

    typedef struct {
        int ht; int hw; int lines;
        bit align; bit do_rst; bit glitch; bit kill;
        int fl; int ll; int hsw; bit lck; int err;
    } row_t;

    typedef struct {
        int fl; int ll; int hsw; int vpos; int ls; int lck; int err;
    } exp_t;

    row_t rows[NROWS];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   err_seen = 0;
    int   frame_no = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_h_pos"},       int'(vif.h_pos), 0);
        chk({tag, "_v_pos"},       int'(vif.v_pos), 0);
        chk({tag, "_line_start"},  int'(vif.line_start), 0);
        chk({tag, "_frame_start"}, int'(vif.frame_start), 0);
        chk({tag, "_line_len"},    int'(vif.line_len), 0);
        chk({tag, "_hs_width"},    int'(vif.hs_width), 0);
        chk({tag, "_frame_lines"}, int'(vif.frame_lines), 0);
        chk({tag, "_locked"},      int'(vif.locked), 0);
        chk({tag, "_sync_err"},    int'(vif.sync_err), 0);
    endtask

    // Monitor: counts sync_err pulses and checks each frame start against the scoreboard.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rst) begin
            if (vif.sync_err) err_seen++;
            if (vif.frame_start) begin
                frame_no++;
                $display("frame_start %0d: frame_lines=%0d line_len=%0d hs_width=%0d v_pos=%0d locked=%0d sync_errs=%0d",
                         frame_no, vif.frame_lines, vif.line_len, vif.hs_width, vif.v_pos, vif.locked, err_seen);
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame_start", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_lines", int'(vif.frame_lines), e.fl);
                    chk("line_len",    int'(vif.line_len), e.ll);
                    chk("hs_width",    int'(vif.hs_width), e.hsw);
                    chk("v_pos",       int'(vif.v_pos), e.vpos);
                    chk("line_start",  int'(vif.line_start), e.ls);
                    chk("locked",      int'(vif.locked), e.lck);
                    chk("sync_err_cnt", err_seen, e.err);
                end
            end
        end
    end

    task automatic send_frame(input row_t r);
        exp_t e;
        int   vs0;
        int   line;
        int   off;
        int   last;
        logic hs;
        e.fl = r.fl; e.ll = r.ll; e.hsw = r.hsw; e.lck = int'(r.lck); e.err = r.err;
        e.vpos = r.align ? 1 : 0;
        e.ls   = r.align ? 1 : 0;
        exp_q.push_back(e);
        vs0  = r.align ? 0 : 10;
        last = r.lines * r.ht - 1;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            if (r.glitch && c == 5 * r.ht + 36) begin
                chk("glitch_line_len", int'(vif.line_len), 20);
                chk("glitch_hs_width", int'(vif.hs_width), 10);
                chk("glitch_locked",   int'(vif.locked), 0);
            end
            line = c / r.ht;
            off  = c % r.ht;
            hs   = (off < r.hw);
            if (r.kill && line > 0) hs = 1'b0;
            if (r.glitch && line == 5 && off >= 20 && off < 30) hs = 1'b1;
            vif.hsync_in = hs;
            vif.vsync_in = (c >= vs0 && c < vs0 + 2 * r.ht);
            if (r.do_rst && c == 100) begin
                chk("pre_reset_locked", int'(vif.locked), 1);
                #2 rst = 1'b0;
                #1 check_all_zero("async_rst");
            end
            if (r.do_rst && c == last) rst = 1'b1;
        end
        if (r.kill) begin
            chk("dead_h_pos",  int'(vif.h_pos), 4095);
            chk("dead_locked", int'(vif.locked), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            ht  hw  lines al rs gl kl   fl  ll  hsw lck err
        rows[0]  = '{HT, HW, VT,   1, 0, 0, 0,  0,  0,  0,  0,  0};
        rows[1]  = '{HT, HW, VT,   1, 0, 0, 0, 12, 40,  6,  0,  0};
        rows[2]  = '{HT, HW, VT,   1, 0, 0, 0, 12, 40,  6,  1,  0};
        rows[3]  = '{HT, HW, VT,   1, 1, 0, 0, 12, 40,  6,  1,  0};
        rows[4]  = '{HT, HW, VT,   0, 0, 0, 0,  0,  0,  6,  0,  0};
        rows[5]  = '{HT, HW, VT,   0, 0, 0, 0, 12, 40,  6,  0,  0};
        rows[6]  = '{HT, HW, VT,   0, 0, 0, 0, 12, 40,  6,  1,  0};
        rows[7]  = '{HT, HW, VT,   0, 0, 1, 0, 12, 40,  6,  1,  0};
        rows[8]  = '{HT, HW, VT,   0, 0, 0, 0, 13, 40,  6,  0,  1};
        rows[9]  = '{HT, HW, VT,   0, 0, 0, 0, 12, 40,  6,  0,  1};
        rows[10] = '{HT, HW, VT,   0, 0, 0, 0, 12, 40,  6,  1,  1};
        rows[11] = '{HT, HW, 110,  0, 0, 0, 1, 12, 40,  6,  1,  1};
        rows[12] = '{HT, HW, VT,   0, 0, 0, 0, 12, 40,  6,  0,  2};
        rows[13] = '{HT, HW, VT,   0, 0, 0, 0, 12, 40,  6,  0,  2};
        rows[14] = '{HT, HW, VT,   0, 0, 0, 0, 12, 40,  6,  1,  2};
        rows[15] = '{HT, HW, VT-1, 0, 0, 0, 0, 12, 40,  6,  1,  2};
        rows[16] = '{HT, HW, VT,   0, 0, 0, 0, 11, 40,  6,  0,  3};
        rows[17] = '{HT, HW, VT,   0, 0, 0, 0, 12, 40,  6,  0,  3};
        rows[18] = '{HT, HW, VT,   0, 0, 0, 0, 12, 40,  6,  1,  3};
        rows[19] = '{HT, HW, VT,   0, 0, 0, 0, 12, 40,  6,  1,  3};

        vif.hsync_in = 1'b0;
        vif.vsync_in = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        for (int i = 0; i < NROWS; i++) send_frame(rows[i]);

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("total_sync_err", err_seen, 3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA timing generator: samples the hsync/vsync pins (io[8]/io[7]) of an incoming VGA stream in the same 50 MHz domain.
- Recovers line/frame position, measures line length, hsync pulse width and frame height, and reports lock against the expected 800x600-class timing.
- Used for loopback self-test of the generator and as a timing front end for future capture logic.

Parameters:
- H_TOTAL, 1041, expected clocks per line (hsync rise to rise)
- V_TOTAL, 667, expected hsync rising edges per frame (vsync rise to rise)
- HS_WIDTH, 120, expected hsync high width in clocks
- LOCK_FRAMES, 2, consecutive good frames needed to lock (1..15)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-low reset
- hsync_in  in  1  horizontal sync, active-high, asynchronous to clk
- vsync_in  in  1  vertical sync, active-high, asynchronous to clk
- h_pos  out  12  clocks since last hsync rising edge, saturating
- v_pos  out  11  hsync edges since last vsync rising edge, saturating
- line_start  out  1  one-cycle pulse on detected hsync rise
- frame_start  out  1  one-cycle pulse on detected vsync rise
- line_len  out  12  last measured line length in clocks
- hs_width  out  12  last measured hsync high width in clocks
- frame_lines  out  11  last measured lines per frame
- locked  out  1  timing matches parameters
- sync_err  out  1  one-cycle pulse when lock is lost

Behaviour:
- Reset (rst=0, async): all outputs 0, counters 0, FSM UNLOCKED, synchronizers 0, first-edge flags cleared.
- Input path: two-flop synchronizer per sync, plus one delay flop for edge detect. hs_rise = hs_s & ~hs_d. Pin-to-pulse latency is 3 clocks. line_start = hs_rise and frame_start = vs_rise, both registered outputs.
- h_cnt (12b): 0 on hs_rise, else +1, saturating at 4095. h_pos = h_cnt.
- On hs_rise, if an earlier hs_rise has been seen since reset: line_len <= h_cnt+1, and line_bad is set if h_cnt+1 != H_TOTAL. The first edge after reset only arms the measurement.
- hs_width: a width counter runs while hs_s=1. On the hs falling edge, hs_width <= count and the counter clears. A width != HS_WIDTH sets line_bad.
- v_cnt (11b): on vs_rise, v_cnt <= 0, or 1 if hs_rise occurs in the same cycle (vsync takes priority and that edge counts as line 0). On hs_rise alone, v_cnt +1, saturating at 2047. v_pos = v_cnt.
- On vs_rise, if an earlier vs_rise has been seen: frame_lines <= v_cnt. frame_ok = (v_cnt == V_TOTAL) && !line_bad. line_bad then clears.
- Timeout: h_cnt reaching 4095 sets line_bad and forces loss of lock (dead or absent hsync).
- FSM, state encoding free:
  - UNLOCKED: on first vs_rise go to MEASURE with good_cnt=0.
  - MEASURE: on vs_rise, if frame_ok, good_cnt+1, and when it reaches LOCK_FRAMES go to LOCKED. Else good_cnt=0 and stay.
  - LOCKED: locked=1. Any line_bad event (wrong line_len, wrong width, timeout) or !frame_ok at vs_rise returns to MEASURE with good_cnt=0, locked=0 next cycle, and a one-cycle sync_err pulse.
  - Timeout in MEASURE returns to UNLOCKED and clears the first-edge flags.
- Measurement registers keep their last value until the next valid edge. They are not cleared on lock loss.
- All arithmetic is unsigned. The +1 on line_len is computed in 12 bits and saturates at 4095.

Test Plan:
- Drive from the VGA generator (rst held high, defaults) -> line_len=1041, hs_width=120, frame_lines=667. locked rises in the cycle after the 3rd vs_rise (1 arm + 2 good frames). No sync_err.
- Locked, then inject one extra 10-clock hsync pulse mid-line -> line_len < 1041 latched, sync_err pulses once, locked=0, and relock after 2 further clean frames.
- Locked, then hold hsync_in low -> h_pos saturates at 4095, sync_err pulses, FSM returns to UNLOCKED, and relock takes 3 vs_rise edges again.
- Align hsync and vsync rising edges in the same clock -> v_pos=1 after the edge, frame_start and line_start both pulse, and frame_lines is unchanged relative to the aligned case.
- Assert rst low mid-frame while locked -> all outputs 0 immediately (asynchronous). After release, the first edges only arm the measurement and locked stays 0 until the 3rd vs_rise.
- Frame with 666 lines (V_TOTAL mismatch) -> frame_lines=666, good_cnt resets, and locked is not asserted or is dropped with sync_err.
